// File: rtl/seven_seg_pkg.sv
// Shared constants for the four-digit seven-segment scanner: active-low
// segment patterns (bit order g..a) and default divider values.
package seven_seg_pkg;

  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam int DEFAULT_BLINK_DIV   = 25000000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Per-frame snapshot of the display inputs, so a frame never mixes old and new values.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
  } shadow_t;

endpackage

// File: rtl/seven_seg_scan_decoder.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Define SEVEN_SEG_HEX_EN to render A-F; otherwise 10-15 are blank.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (val_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
`ifdef SEVEN_SEG_HEX_EN
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a four-digit common-anode display with per-digit
// blink and tear-free frame updates. Hex glyphs via SEVEN_SEG_HEX_EN (in seg_decoder).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int BLINK_DIV   = DEFAULT_BLINK_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blink_mask,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  shadow_t       shadow_q, shadow_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          slot_tick, blink_tick;
  logic [3:0]    cur_val;
  logic [6:0]    cur_pat;

  assign cur_val = shadow_q.digits[{idx_q, 2'b00} +: 4];

  seg_decoder u_dec (
    .val_i (cur_val),
    .seg_o (cur_pat)
  );

  always_comb begin
    slot_tick  = (ref_cnt_q == REF_LAST);
    blink_tick = (blk_cnt_q == BLK_LAST);
    ref_cnt_d  = slot_tick  ? '0 : ref_cnt_q + RW'(1);
    blk_cnt_d  = blink_tick ? '0 : blk_cnt_q + BW'(1);
    idx_d      = slot_tick  ? idx_q + 2'd1 : idx_q;
    phase_d    = blink_tick ? ~phase_q : phase_q;
    shadow_d   = shadow_q;
    // Snapshot only as the scan wraps from digit 3 back to digit 0.
    if (slot_tick && (idx_q == 2'd3)) begin
      shadow_d = '{digits: digits, dp: dp, blink_mask: blink_mask};
    end
  end

  always_comb begin
    seg_d = {~shadow_q.dp[idx_q], cur_pat};
    an_d  = ~(4'b0001 << idx_q);
    if (phase_q && shadow_q.blink_mask[idx_q]) begin
      an_d = 4'hF;
    end
    // Blanking gates only the outputs; counters keep the scan phase running.
    if (!en) begin
      seg_d = 8'hFF;
      an_d  = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
      blk_cnt_q <= '0;
      idx_q     <= '0;
      phase_q   <= 1'b0;
      shadow_q  <= '0;
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with REFRESH_DIV=4, BLINK_DIV=16: a cycle-count
// model compared every cycle, plus hand-computed literal checkpoints.
module tb_seven_seg_scan;

  localparam int R = 4;
  localparam int B = 16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic [7:0]  seg;
  logic [3:0]  an;

  int total;
  int bad;
  int e;
  bit chk_on;

  seven_seg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEVEN_SEG_HEX_EN
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif

  // Expected {an, seg} after n clock edges of scanning, from the display rules directly.
  function automatic logic [11:0] model_out(input int n, input logic [15:0] sd,
                                            input logic [3:0] sdp, input logic [3:0] sbm,
                                            input logic ena);
    int idx;
    int ph;
    logic [3:0] v;
    logic [3:0] a;
    logic [7:0] s;
    idx = (n / R) % 4;
    ph  = (n / B) % 2;
    v   = 4'((sd >> (4 * idx)) & 16'hF);
    a   = 4'hF;
    a[idx] = 1'b0;
    if (ph == 1 && sbm[idx]) a = 4'hF;
    s = {~sdp[idx], PAT[v]};
    if (!ena) return 12'hFFF;
    return {a, s};
  endfunction

  int          m_n;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_bm;
  logic [11:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n   <= 0;
      m_dig <= '0;
      m_dp  <= '0;
      m_bm  <= '0;
      m_exp <= 12'hFFF;
    end else begin
      m_exp <= model_out(m_n, m_dig, m_dp, m_bm, en);
      m_n   <= m_n + 1;
      if ((m_n + 1) % (4 * R) == 0) begin
        m_dig <= digits;
        m_dp  <= dp;
        m_bm  <= blink_mask;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if ({an, seg} !== m_exp) begin
        bad++;
        $display("FAIL model_cycle n=%0d an/seg got=%h/%h expected=%h/%h",
                 m_n, an, seg, m_exp[11:8], m_exp[7:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s an/seg got=%h/%h expected=%h/%h", name, got[11:8], got[7:0],
               exp[11:8], exp[7:0]);
    end
  endtask

  task automatic go(input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  initial begin
    total = 0; bad = 0; e = 0; chk_on = 0;
    rst_n = 1'b0; en = 1'b1; digits = 16'h1234; dp = 4'h0; blink_mask = 4'h0;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", {an, seg}, 12'hFFF);
    chk_on = 1;
    @(posedge clk);
    #2 rst_n = 1'b1; e = 0;

    go(1);  chk("first_edge_zero", {an, seg}, {4'hE, 8'hC0});
    go(17); chk("scan_d0_4", {an, seg}, {4'hE, 8'h99});
    go(21); chk("scan_d1_3", {an, seg}, {4'hD, 8'hB0});
    go(25); chk("scan_d2_2", {an, seg}, {4'hB, 8'hA4});
    go(29); chk("scan_d3_1", {an, seg}, {4'h7, 8'hF9});

    go(37); #1 digits = 16'h5678;
    go(38); chk("tear_s1", {an, seg}, {4'hD, 8'hB0});
    go(42); chk("tear_s2", {an, seg}, {4'hB, 8'hA4});
    go(46); chk("tear_s3", {an, seg}, {4'h7, 8'hF9});
    go(49); chk("tear_next_8", {an, seg}, {4'hE, 8'h80});

    go(50); #1 blink_mask = 4'b0001;
    go(65); chk("blink_on_phase0", {an, seg}, {4'hE, 8'h80});
    go(81); chk("blink_off_phase1", {an, seg}, {4'hF, 8'h80});
    go(85); chk("blink_other_digit", {an, seg}, {4'hD, 8'hF8});
    go(97); chk("blink_on_again", {an, seg}, {4'hE, 8'h80});

    go(100); #1 digits = 16'h000A; dp = 4'b0001; blink_mask = 4'h0;
`ifdef SEVEN_SEG_HEX_EN
    go(113); chk("hex_A", {an, seg}, {4'hE, 8'h08});
`else
    go(113); chk("hex_A_blank", {an, seg}, {4'hE, 8'h7F});
`endif

    go(122); #1 en = 1'b0;
    go(127); chk("en_off_blank", {an, seg}, 12'hFFF);
    go(132); #1 en = 1'b1;
    go(133); chk("en_resume_d1", {an, seg}, {4'hD, 8'hC0});

    go(138); #2 rst_n = 1'b0;
    #1 chk("rst_async_blank", {an, seg}, 12'hFFF);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1; e = 0;
    go(1);  chk("rst_release_d0", {an, seg}, {4'hE, 8'hC0});
    go(40);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, 100000, clk cycles per digit slot (legal range >= 2).
REQ-002 SHALL have parameter BLINK_DIV, 25000000, clk cycles per blink half-period (legal range >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state is clocked on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  display enable; 0 blanks all digits.
REQ-006 SHALL have port digits  input  16  four 4-bit values; [3:0] is the rightmost digit (digit 0), [15:12] is digit 3.
REQ-007 SHALL have port dp  input  4  decimal point per digit, 1 = lit.
REQ-008 SHALL have port blink_mask  input  4  1 = blink that digit (adjust mode).
REQ-009 SHALL have port seg  output  8  active-low segments; seg[6:0] = g..a, seg[7] = dp.
REQ-010 SHALL have port an  output  4  active-low one-hot anode select; an[i] drives digit i.

Function
REQ-011 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; a wrap is a slot tick.
REQ-012 The 2-bit digit index SHALL advance 0->1->2->3->0 on each slot tick.
REQ-013 The digits, dp and blink_mask inputs SHALL be captured into a shadow register on the slot tick where index goes 3->0 (frame boundary); mid-frame input changes SHALL NOT appear until the next frame.
REQ-014 The blink counter SHALL count 0..BLINK_DIV-1; on each wrap blink_phase SHALL toggle.
REQ-015 seg and an SHALL be registered, reflecting index, shadow and blink_phase with exactly 1 cycle latency.
REQ-016 For the active slot, an SHALL be low only at bit index; seg[6:0] = decode(shadow digit), seg[7] = ~shadow dp.
REQ-017 If blink_phase = 1 and the shadow blink_mask bit of the active digit is 1, an SHALL be 4'b1111 for that slot.
REQ-018 If en = 0, an SHALL be 4'b1111 and seg 8'hFF on the next cycle; the counters SHALL keep running, so re-enabling SHALL NOT reset the scan phase.
REQ-019 The decoder SHALL map 0-9 to the standard digit patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-020 The counter widths SHALL be $clog2 of the corresponding divider, and no counter SHALL exceed its divider minus one.

Reset
REQ-021 While rst_n = 0: refresh counter, blink counter, index, blink_phase and shadow SHALL be 0, seg SHALL be 8'hFF and an SHALL be 4'b1111.
REQ-022 Reset assertion mid-slot SHALL blank the outputs immediately and asynchronously.
REQ-023 After rst_n rises, the first edge SHALL drive digit 0 from a zero shadow (seg 8'hC0, an 4'b1110).

Configuration
REQ-024 With SEVEN_SEG_HEX_EN defined, values 10-15 SHALL render A, b, C, d, E, F; without it, they SHALL render blank (seg[6:0] = 7'b1111111).

Structure
REQ-025 Package seven_seg_pkg SHALL hold the segment pattern constants for 0-F and blank, plus the default divider constants.
REQ-026 Sub-module seg_decoder (combinational, 4-bit value in, 7-bit active-low pattern out) SHALL be instantiated once; it owns the SEVEN_SEG_HEX_EN switch.

Verification (REFRESH_DIV = 4, BLINK_DIV = 16)
REQ-027 Scan order: digits = 16'h1234, en = 1, no blink -> after the first frame boundary, the slots SHALL show an 1110/1101/1011/0111 with seg 8'h99 ("4"), 8'hB0 ("3"), 8'hA4 ("2"), 8'hF9 ("1"), 4 cycles each.
REQ-028 Tear-free update: change digits from 16'h1234 to 16'h5678 during slot 1 -> slots 1-3 SHALL still show 3, 2, 1, and slot 0 of the next frame SHALL show "8" (8'h80).
REQ-029 Blink: blink_mask = 4'b0001 -> an SHALL be 1111 during digit-0 slots for 16 cycles, then show digit 0 for 16 cycles, alternating; the other digits SHALL be unaffected.
REQ-030 Hex macro: digits = 16'h000A, dp = 4'b0001 -> digit-0 slot seg SHALL be 8'h08 with SEVEN_SEG_HEX_EN defined and 8'h7F without it.
REQ-031 Enable/reset: en = 0 for 10 cycles -> an = 1111 and seg = FF, and the scan SHALL resume at the index the counter has reached when en returns; rst_n pulse mid-slot 2 -> outputs blank immediately, and after release digit 0 SHALL show with seg 8'hC0.
